// File: rtl/id_ex_skid.sv
// ID/EX pipeline boundary: 2-entry valid/ready skid buffer with registered outputs.
// Optional `ID_EX_NOP_SQUASH_EN forces ex_* payload to NOP whenever ex_valid_o is low.
module id_ex_skid #(
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3,
  parameter int DATA_W   = 32,
  parameter int RADDR_W  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic                id_valid_i,
  output logic                id_ready_o,
  input  logic [ALUOP_W-1:0]  id_aluop_i,
  input  logic [ALUSEL_W-1:0] id_alusel_i,
  input  logic [DATA_W-1:0]   id_reg1_i,
  input  logic [DATA_W-1:0]   id_reg2_i,
  input  logic [RADDR_W-1:0]  id_wd_i,
  input  logic                id_wreg_i,
  output logic                ex_valid_o,
  input  logic                ex_ready_i,
  output logic [ALUOP_W-1:0]  ex_aluop_o,
  output logic [ALUSEL_W-1:0] ex_alusel_o,
  output logic [DATA_W-1:0]   ex_reg1_o,
  output logic [DATA_W-1:0]   ex_reg2_o,
  output logic [RADDR_W-1:0]  ex_wd_o,
  output logic                ex_wreg_o
);

  // state | meaning
  // EMPTY | nothing buffered, ex_valid_o low
  // BUSY  | main holds the bundle shown to EX
  // FULL  | main shown to EX, skid holds the next bundle; input stalled
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;

  localparam int PW = ALUOP_W + ALUSEL_W + 2*DATA_W + RADDR_W + 1;

  state_t        state_q, state_d;
  logic [PW-1:0] main_q, skid_q, in_pl, out_pl;
  logic          in_xfer, out_xfer;
  logic          load_main, load_skid, main_from_skid;

  assign in_pl = {id_aluop_i, id_alusel_i, id_reg1_i, id_reg2_i, id_wd_i, id_wreg_i};

  assign ex_valid_o = (state_q != EMPTY);
  assign id_ready_o = !rst && (state_q != FULL);
  assign in_xfer    = id_valid_i && id_ready_o;
  assign out_xfer   = ex_valid_o && ex_ready_i;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d   = BUSY;
          load_main = 1'b1;
        end
      end
      BUSY: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_d        = BUSY;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Squash drops the incoming bundle and anything still buffered.
    if (flush_i) begin
      state_d        = EMPTY;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_main)           main_q <= in_pl;
      else if (main_from_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_pl;
    end
  end

`ifdef ID_EX_NOP_SQUASH_EN
  assign out_pl = ex_valid_o ? main_q : '0;
`else
  assign out_pl = main_q;
`endif

  assign {ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o} = out_pl;

endmodule

// File: doc/id_ex_skid.md
Name: id_ex_skid

Overview:
Pipeline boundary between the ID stage and the EX stage, replacing a bare ID/EX flop stage with a 2-entry valid/ready skid buffer. It captures the decoded bundle {aluop, alusel, reg1, reg2, wd, wreg} and presents it to EX with a registered 1-cycle latency. It sustains 1 instruction/cycle while absorbing one cycle of EX back-pressure without a combinational ready path. A flush input discards all in-flight entries, for branch or exception squash.

Parameters:
ALUOP_W, 8, width of aluop field (matches AluOpBus)
ALUSEL_W, 3, width of alusel field (matches AluSelBus)
DATA_W, 32, operand width (matches RegBus)
RADDR_W, 5, destination register address width (matches RegAddrBus)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset: synchronous, active-high
flush_i  input  1  discard all buffered entries and the same-cycle input
id_valid_i  input  1  ID presents a valid bundle
id_ready_o  output  1  buffer can accept; transfer = id_valid_i & id_ready_o
id_aluop_i  input  ALUOP_W  decoded ALU sub-op
id_alusel_i  input  ALUSEL_W  result class
id_reg1_i  input  DATA_W  source operand 1
id_reg2_i  input  DATA_W  source operand 2
id_wd_i  input  RADDR_W  destination register
id_wreg_i  input  1  write-enable for destination
ex_valid_o  output  1  bundle on ex_* outputs is valid
ex_ready_i  input  1  EX consumes; transfer = ex_valid_o & ex_ready_i
ex_aluop_o  output  ALUOP_W  registered aluop
ex_alusel_o  output  ALUSEL_W  registered alusel
ex_reg1_o  output  DATA_W  registered operand 1
ex_reg2_o  output  DATA_W  registered operand 2
ex_wd_o  output  RADDR_W  registered destination
ex_wreg_o  output  1  registered write-enable

Behaviour:
- Storage: main register (drives ex_*), skid register (overflow entry). State: EMPTY, BUSY (main valid), FULL (main + skid valid).
- in = id_valid_i & id_ready_o; out = ex_valid_o & ex_ready_i.
- ex_valid_o = (state != EMPTY). id_ready_o = !rst & (state != FULL). Both are decoded from state only, with no combinational path from ex_ready_i or id_valid_i.
- EMPTY: in -> BUSY, main <= input.
- BUSY: in & out -> BUSY, main <= input. in & !out -> FULL, skid <= input. !in & out -> EMPTY. Otherwise hold.
- FULL: out -> BUSY, main <= skid. Otherwise hold. No input is accepted in FULL.
- Latency: a bundle accepted in cycle N appears on ex_* with ex_valid_o=1 in cycle N+1, if it arrived in EMPTY or BUSY-with-out.
- Ordering: strict FIFO. No reorder or duplication. Each accepted bundle is presented exactly once.
- While ex_valid_o=1 & ex_ready_i=0, all ex_* outputs are held stable.
- flush_i=1: next state is EMPTY regardless of in/out. The same-cycle input is dropped. A same-cycle out still counts as consumed by EX. flush_i has priority below rst.
- rst=1: state <= EMPTY, main and skid payload <= 0 (aluop=EXE_NOP_OP=0, alusel=EXE_RES_NOP=0, wreg=0, wd=0). ex_valid_o=0 and id_ready_o=0 during reset. id_ready_o=1 in the first cycle after rst drops. Reset mid-transfer discards everything.
- Payload is stored verbatim, with no width conversion.

Optional Feature:
Macro ID_EX_NOP_SQUASH_EN.
- Defined: when ex_valid_o=0, ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o and ex_wreg_o are forced to 0 (NOP, no write). The payload presented to EX is then always safe even if EX ignores valid.
- Undefined: ex_* outputs show main register contents unconditionally. Stale values persist after drain, and EX must qualify with ex_valid_o. Handshake and state behaviour are identical either way.

Test Plan:
- Reset: hold rst 2 cycles, then release -> ex_valid_o=0, all ex_*=0 during reset; id_ready_o=0 in reset, 1 in the next cycle.
- Streaming: ex_ready_i=1, present SUBU bundles reg1=0x10,0x20,0x30 on consecutive cycles -> same bundles on ex_* in cycles N+1..N+3, id_ready_o stays 1, no bubbles.
- Back-pressure: accept A(reg1=0xA) then B(reg1=0xB) with ex_ready_i=0 -> state FULL, id_ready_o=0, ex_reg1_o holds 0xA. Raise ex_ready_i -> A consumed, then B on the next cycle, id_ready_o returns to 1.
- Flush while FULL with C valid on input -> next cycle ex_valid_o=0, id_ready_o=1. A, B and C never appear, and the next accepted bundle D appears normally.
- Simultaneous in & out in BUSY: main=0x1, input 0x2, ex_ready_i=1 -> next cycle ex_reg1_o=0x2, state BUSY.
- ID_EX_NOP_SQUASH_EN defined, after draining a bundle with wreg=1, wd=5 -> ex_wreg_o=0, ex_wd_o=0. Undefined -> ex_wd_o=5, ex_valid_o=0.
